// File: rtl/dma_io_device.sv
// Peripheral endpoint of the 8237A DMA handshake: a shared byte FIFO, DREQ
// generation, strobe-edge commits for IOR/IOW, EOP termination and error flags.
module dma_io_device #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int THRESH = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              arm,
    input  logic              dir,
    input  logic              demand,
    output logic              DREQ,
    input  logic              DACK,
    input  logic              IOR_N,
    input  logic              IOW_N,
    input  logic              EOP_N,
    input  logic [DATA_W-1:0] DB_IN,
    output logic [DATA_W-1:0] DB_OUT,
    output logic              DB_OE,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_ready,
    output logic [15:0]       xfer_count,
    output logic              done,
    output logic              underrun,
    output logic              overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {IDLE, WAIT, REQ, ACTIVE, GAP} state_t;

    state_t              state;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [AW-1:0]       wptr, rptr;
    logic [CW-1:0]       count, count_nx;
    logic [DATA_W-1:0]   cap, push_data;
    logic                dir_q, demand_q, ior_low_q, iow_low_q;
    logic                empty, full, strobe_rise, commit, eop;
    logic                dma_push, dma_pop, loc_push, loc_pop, push, pop;
    logic                c_now, c_next;

    function automatic logic req_ok(input logic d, input logic [CW-1:0] cnt);
        if (d)
            return (DEPTH - int'(cnt)) >= THRESH;
        else
            return int'(cnt) >= THRESH;
    endfunction

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // A commit is the rising edge of the active strobe while acknowledged.
    assign strobe_rise = dir_q ? (iow_low_q & IOW_N) : (ior_low_q & IOR_N);
    assign commit      = strobe_rise & DACK & (state != IDLE) & ~arm;
    assign eop         = ~EOP_N & DACK & (state != IDLE);

    assign loc_pop  = dir_q & ~empty & rd_ready;
    assign dma_pop  = commit & ~dir_q & ~empty;
    assign dma_push = commit & dir_q & (~full | loc_pop);
    assign wr_ready = ~dir_q & (~full | dma_pop);
    assign loc_push = ~dir_q & wr_valid & wr_ready;

    assign push      = dma_push | loc_push;
    assign pop       = dma_pop | loc_pop;
    assign push_data = dir_q ? cap : wr_data;
    assign count_nx  = count + CW'(push) - CW'(pop);

    assign c_now  = req_ok(dir_q, count);
    assign c_next = req_ok(dir_q, count_nx);

    assign DB_OE    = DACK & ~IOR_N & ~dir_q;
    assign DB_OUT   = (DB_OE && !empty) ? mem[rptr] : '0;
    assign rd_valid = dir_q & ~empty;
    assign rd_data  = rd_valid ? mem[rptr] : '0;

    always_ff @(posedge CLK) begin
        if (push)
            mem[wptr] <= push_data;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            ior_low_q <= 1'b0;
            iow_low_q <= 1'b0;
            cap       <= '0;
        end else begin
            ior_low_q <= ~IOR_N;
            iow_low_q <= ~IOW_N;
            if (!IOW_N)
                cap <= DB_IN;
            if (push)
                wptr <= wptr + AW'(1);
            if (pop)
                rptr <= rptr + AW'(1);
            count <= count_nx;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= IDLE;
            DREQ       <= 1'b0;
            done       <= 1'b0;
            dir_q      <= 1'b0;
            demand_q   <= 1'b0;
            xfer_count <= '0;
            underrun   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (arm) begin
                state      <= WAIT;
                DREQ       <= 1'b0;
                dir_q      <= dir;
                demand_q   <= demand;
                xfer_count <= '0;
                underrun   <= 1'b0;
                overrun    <= 1'b0;
            end else begin
                if (dma_pop || dma_push)
                    xfer_count <= xfer_count + 16'd1;
                if (commit && !dir_q && empty)
                    underrun <= 1'b1;
                if (commit && dir_q && !dma_push)
                    overrun <= 1'b1;
                // Commit bookkeeping above still lands when EOP terminates.
                if (eop) begin
                    state <= IDLE;
                    DREQ  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    case (state)
                        IDLE: DREQ <= 1'b0;
                        WAIT: begin
                            if (c_now) begin
                                state <= REQ;
                                DREQ  <= 1'b1;
                            end
                        end
                        REQ: begin
                            if (DACK) begin
                                state <= ACTIVE;
                                DREQ  <= 1'b1;
                            end else if (!c_now) begin
                                state <= WAIT;
                                DREQ  <= 1'b0;
                            end
                        end
                        ACTIVE: begin
                            if (commit) begin
                                if (demand_q && c_next) begin
                                    DREQ <= 1'b1;
                                end else if (demand_q) begin
                                    state <= WAIT;
                                    DREQ  <= 1'b0;
                                end else begin
                                    state <= GAP;
                                    DREQ  <= 1'b0;
                                end
                            end else if (!DACK) begin
                                state <= c_now ? REQ : WAIT;
                                DREQ  <= c_now;
                            end
                        end
                        GAP: begin
                            // Re-evaluate directly so DREQ is low for exactly one cycle.
                            state <= c_now ? REQ : WAIT;
                            DREQ  <= c_now;
                        end
                        default: begin
                            state <= IDLE;
                            DREQ  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_dma_io_device.sv
// Self-checking bench for dma_io_device: combinational bus table, directed
// handshake sequences and a queue-based reference model under random traffic.
module tb_dma_io_device;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       arm = 1'b0, dir = 1'b0, demand = 1'b0;
    logic       DREQ, DACK = 1'b0, IOR_N = 1'b1, IOW_N = 1'b1, EOP_N = 1'b1;
    logic [7:0] DB_IN = '0, DB_OUT;
    logic       DB_OE;
    logic       wr_valid = 1'b0, wr_ready;
    logic [7:0] wr_data = '0;
    logic       rd_valid, rd_ready = 1'b0;
    logic [7:0] rd_data;
    logic [15:0] xfer_count;
    logic       done, underrun, overrun;

    int checks = 0;
    int errors = 0;

    dma_io_device #(.DATA_W(8), .DEPTH(16), .THRESH(1)) dut (
        .CLK(CLK), .RESET(RESET), .arm(arm), .dir(dir), .demand(demand),
        .DREQ(DREQ), .DACK(DACK), .IOR_N(IOR_N), .IOW_N(IOW_N), .EOP_N(EOP_N),
        .DB_IN(DB_IN), .DB_OUT(DB_OUT), .DB_OE(DB_OE),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .xfer_count(xfer_count), .done(done), .underrun(underrun), .overrun(overrun)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        arm = 1'b0; DACK = 1'b0; IOR_N = 1'b1; IOW_N = 1'b1; EOP_N = 1'b1;
        wr_valid = 1'b0; rd_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
    endtask

    task automatic push_byte(input logic [7:0] d);
        wr_valid = 1'b1; wr_data = d;
        @(negedge CLK);
        wr_valid = 1'b0;
    endtask

    task automatic arm_blk(input logic d, input logic dem);
        arm = 1'b1; dir = d; demand = dem;
        @(negedge CLK);
        arm = 1'b0;
    endtask

    // One acknowledged strobe cycle; returns at the negedge after the commit edge.
    task automatic dma_cycle(input logic rd, input logic [7:0] wdata, input logic eop,
                             input logic do_push, input logic [7:0] pdata,
                             output logic [7:0] seen, output logic wr_rdy_seen);
        DACK = 1'b1;
        @(negedge CLK);
        if (rd) IOR_N = 1'b0;
        else begin IOW_N = 1'b0; DB_IN = wdata; end
        #1 seen = DB_OUT;
        @(negedge CLK);
        IOR_N = 1'b1; IOW_N = 1'b1; EOP_N = ~eop;
        wr_rdy_seen = 1'b0;
        if (do_push) begin
            wr_valid = 1'b1; wr_data = pdata;
            #1 wr_rdy_seen = wr_ready;
        end
        @(negedge CLK);
        DACK = 1'b0; EOP_N = 1'b1; wr_valid = 1'b0;
    endtask

    typedef struct {
        logic       d;
        logic       dack;
        logic       ior_n;
        logic       iow_n;
        logic       oe;
        logic [7:0] out;
    } vec_t;

    vec_t vecs[12];
    logic [7:0] seen;
    logic       wrs;
    logic [7:0] q[$];
    int         m_xfer;
    logic       m_under, m_over;

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};

        // Reset state, checked while reset is held
        #3;
        chk("rst_dreq", DREQ, 0);   chk("rst_oe", DB_OE, 0);   chk("rst_dbout", DB_OUT, 0);
        chk("rst_done", done, 0);   chk("rst_xfer", xfer_count, 0);
        chk("rst_under", underrun, 0); chk("rst_over", overrun, 0);
        chk("rst_rdv", rd_valid, 0); chk("rst_wrr", wr_ready, 1);
        do_reset();

        // Combinational bus-drive table
        push_byte(8'h5A);
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].d != dut.dir_q) arm_blk(vecs[i].d, 1'b0);
            DACK = vecs[i].dack; IOR_N = vecs[i].ior_n; IOW_N = vecs[i].iow_n;
            #1;
            chk($sformatf("tbl%0d_oe", i), DB_OE, vecs[i].oe);
            chk($sformatf("tbl%0d_out", i), DB_OUT, vecs[i].out);
            DACK = 1'b0; IOR_N = 1'b1; IOW_N = 1'b1;
            @(negedge CLK);
        end

        // TO_MEM single mode with underrun on the fourth cycle
        do_reset();
        push_byte(8'hA1); push_byte(8'hB2); push_byte(8'hC3);
        arm_blk(1'b0, 1'b0);
        chk("s_wait_dreq", DREQ, 0);
        @(negedge CLK);
        chk("s_req_dreq", DREQ, 1);
        dma_cycle(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, seen, wrs);
        chk("s_b1", seen, 8'hA1); chk("s_gap1", DREQ, 0); chk("s_x1", xfer_count, 1);
        @(negedge CLK);
        chk("s_regap1", DREQ, 1);
        dma_cycle(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, seen, wrs);
        chk("s_b2", seen, 8'hB2); chk("s_gap2", DREQ, 0);
        @(negedge CLK);
        chk("s_regap2", DREQ, 1);
        dma_cycle(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, seen, wrs);
        chk("s_b3", seen, 8'hC3);
        @(negedge CLK);
        chk("s_empty_dreq", DREQ, 0);
        dma_cycle(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, seen, wrs);
        chk("s_b4", seen, 8'h00); chk("s_under", underrun, 1); chk("s_x3", xfer_count, 3);

        // FROM_MEM demand mode until overrun
        do_reset();
        arm_blk(1'b1, 1'b1);
        @(negedge CLK);
        for (int i = 0; i < 17; i++) begin
            chk($sformatf("d_dreq%0d", i), DREQ, (i < 16) ? 1 : 0);
            dma_cycle(1'b0, 8'(i), 1'b0, 1'b0, 8'h00, seen, wrs);
        end
        chk("d_over", overrun, 1); chk("d_x16", xfer_count, 16);
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("d_rv%0d", i), rd_valid, 1);
            chk($sformatf("d_rd%0d", i), rd_data, i);
            @(negedge CLK);
        end
        rd_ready = 1'b0;
        chk("d_rv_end", rd_valid, 0);

        // EOP coincident with the second IOR rising edge
        do_reset();
        push_byte(8'hA1); push_byte(8'hB2); push_byte(8'hC3);
        arm_blk(1'b0, 1'b0);
        @(negedge CLK);
        dma_cycle(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, seen, wrs);
        chk("e_b1", seen, 8'hA1);
        @(negedge CLK);
        dma_cycle(1'b1, 8'h00, 1'b1, 1'b0, 8'h00, seen, wrs);
        chk("e_b2", seen, 8'hB2); chk("e_done", done, 1);
        chk("e_dreq", DREQ, 0);   chk("e_x2", xfer_count, 2);
        @(negedge CLK);
        chk("e_done_clr", done, 0);
        dma_cycle(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, seen, wrs);
        dma_cycle(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, seen, wrs);
        chk("e_ign_head", seen, 8'hC3); chk("e_ign_x", xfer_count, 2);
        chk("e_ign_dreq", DREQ, 0);     chk("e_ign_done", done, 0);

        // DACK withdrawn in ACTIVE without a strobe
        do_reset();
        push_byte(8'h11); push_byte(8'h22);
        arm_blk(1'b0, 1'b1);
        @(negedge CLK);
        DACK = 1'b1;
        repeat (2) @(negedge CLK);
        DACK = 1'b0;
        @(negedge CLK);
        chk("k_dreq_a", DREQ, 1);
        @(negedge CLK);
        chk("k_dreq_b", DREQ, 1); chk("k_x0", xfer_count, 0);
        dma_cycle(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, seen, wrs);
        chk("k_b1", seen, 8'h11); chk("k_x1", xfer_count, 1); chk("k_dreq_c", DREQ, 1);

        // Full FIFO: push and pop together, then drain across the pointer wrap
        do_reset();
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        chk("f_full_wrr", wr_ready, 0);
        arm_blk(1'b0, 1'b1);
        for (int i = 0; i < 21; i++) begin
            dma_cycle(1'b1, 8'h00, 1'b0, (i < 5), 8'(16 + i), seen, wrs);
            chk($sformatf("f_b%0d", i), seen, i);
            if (i < 5) begin
                chk($sformatf("f_wrr_pop%0d", i), wrs, 1);
                chk($sformatf("f_wrr_after%0d", i), wr_ready, 0);
            end
        end
        chk("f_x21", xfer_count, 21);

        // Reset asserted mid-strobe in ACTIVE
        do_reset();
        arm_blk(1'b1, 1'b0);
        @(negedge CLK);
        DACK = 1'b1;
        @(negedge CLK);
        IOW_N = 1'b0; DB_IN = 8'h77;
        @(negedge CLK);
        #2 RESET = 1'b0;
        #1;
        chk("r_dreq", DREQ, 0); chk("r_oe", DB_OE, 0); chk("r_dbout", DB_OUT, 0);
        chk("r_xfer", xfer_count, 0); chk("r_rdv", rd_valid, 0); chk("r_wrr", wr_ready, 1);
        IOW_N = 1'b1; DACK = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk($sformatf("r_post_dreq%0d", i), DREQ, 0);
        end
        chk("r_post_rdv", rd_valid, 0);

        // Random traffic against a queue model: TO_MEM phase, then FROM_MEM
        do_reset();
        q.delete(); m_xfer = 0; m_under = 1'b0; m_over = 1'b0;
        arm_blk(1'b0, 1'($urandom_range(0, 1)));
        for (int n = 0; n < 200; n++) begin
            int unsigned r = $urandom_range(0, 9);
            if (r < 5) begin
                logic [7:0] d = 8'($urandom);
                wr_valid = 1'b1; wr_data = d;
                #1 chk("rt_wrr", wr_ready, (q.size() < 16) ? 1 : 0);
                if (q.size() < 16) q.push_back(d);
                @(negedge CLK);
                wr_valid = 1'b0;
            end else if (r < 9) begin
                dma_cycle(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, seen, wrs);
                if (q.size() > 0) begin
                    chk("rt_data", seen, q.pop_front());
                    m_xfer++;
                end else begin
                    chk("rt_data_empty", seen, 0);
                    m_under = 1'b1;
                end
            end else begin
                arm_blk(1'b0, 1'($urandom_range(0, 1)));
                m_xfer = 0; m_under = 1'b0;
            end
            chk("rt_xfer", xfer_count, 16'(m_xfer));
            chk("rt_under", underrun, m_under);
        end
        arm_blk(1'b1, 1'($urandom_range(0, 1)));
        m_xfer = 0; m_over = 1'b0;
        for (int n = 0; n < 200; n++) begin
            int unsigned r = $urandom_range(0, 9);
            if (r < 5) begin
                logic [7:0] d = 8'($urandom);
                dma_cycle(1'b0, d, 1'b0, 1'b0, 8'h00, seen, wrs);
                if (q.size() < 16) begin
                    q.push_back(d);
                    m_xfer++;
                end else begin
                    m_over = 1'b1;
                end
            end else begin
                rd_ready = 1'b1;
                #1 chk("rf_rdv", rd_valid, (q.size() > 0) ? 1 : 0);
                if (q.size() > 0) chk("rf_data", rd_data, q.pop_front());
                @(negedge CLK);
                rd_ready = 1'b0;
            end
            chk("rf_xfer", xfer_count, 16'(m_xfer));
            chk("rf_over", overrun, m_over);
            chk("rf_under", underrun, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
